boot_loader_master: RTL and testbench

Bus initiator that fills SRAM from a serial byte stream during boot and then issues the end-of-boot command. It sits between the UART receiver and the shared 68k-style word bus, and drives the same strobe/ack protocol the CPU uses. It writes a received image into RAM, then writes 16'hA9A9 to address 0. The boot device answers that write by leaving bootmode on the next strobe release.

---
 rtl/boot_loader_master.sv | 219 +++++++++++++++++++++
 tb/tb_boot_loader_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_master.sv
// Boot image loader: turns a serial byte stream into strobe/ack word writes, then writes 16'hA9A9 to address 0.
// Optional read-back verification after every word is enabled by defining BOOT_LOADER_VERIFY_EN.
module boot_loader_master #(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [23:0] addr,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_DATA, S_WR, S_REL, S_VRD, S_VREL,
    S_CSUM, S_END_WR, S_END_REL, S_DONE, S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   cnt_q, cnt_d, cnt_dec;
  logic [7:0]    sum_q, sum_d;
  logic [1:0]    hdr_q, hdr_d;
  logic          hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    err_q, err_d;
  logic          done_q, done_d;
  logic          rx_ready_q, rx_ready_d;
  logic          strb_q, strb_d;
  logic          rw_q, rw_d;
  logic          busy_q, busy_d;
  logic          accept, tmo_hit;
`ifdef BOOT_LOADER_VERIFY_EN
  logic [15:0]   rd_q, rd_d;
`else
  logic          unused_data_read;
  assign unused_data_read = ^data_read;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    hdr_d   = hdr_q;
    hi_d    = hi_q;
    tmo_d   = '0;
    err_d   = err_q;
    done_d  = done_q;
`ifdef BOOT_LOADER_VERIFY_EN
    rd_d    = rd_q;
`endif
    accept  = rx_valid && rx_ready_q;
    tmo_hit = (tmo_q == TMO_MAX);
    cnt_dec = cnt_q - 16'd1;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d[23:16] = rx_data;
        hdr_d         = 2'd0;
        state_d       = S_HDR;
      end
      S_HDR: if (accept) begin
        hdr_d = hdr_q + 2'd1;
        case (hdr_q)
          2'd0: addr_d[15:8] = rx_data;
          2'd1: addr_d[7:0]  = {rx_data[7:1], 1'b0};
          2'd2: cnt_d[15:8]  = rx_data;
          default: begin
            cnt_d[7:0] = rx_data;
            hi_d       = 1'b0;
            state_d    = ({cnt_q[15:8], rx_data} != 16'd0) ? S_DATA : S_CSUM;
          end
        endcase
      end
      S_DATA: if (accept) begin
        sum_d = sum_q + rx_data;
        hi_d  = !hi_q;
        if (!hi_q) begin
          wdata_d[15:8] = rx_data;
        end else begin
          wdata_d[7:0] = rx_data;
          state_d      = S_WR;
        end
      end
      // Strobe-high states: ack ends the transfer, otherwise count toward abort
      S_WR: begin
        if (ack) state_d = S_REL;
        else if (tmo_hit) begin
          err_d   = 2'b10;
          state_d = S_ERROR;
        end else tmo_d = tmo_q + TMO_ONE;
      end
      S_REL: begin
`ifdef BOOT_LOADER_VERIFY_EN
        state_d = S_VRD;
`else
        cnt_d   = cnt_dec;
        addr_d  = addr_q + 24'd2;
        hi_d    = 1'b0;
        state_d = (cnt_dec != 16'd0) ? S_DATA : S_CSUM;
`endif
      end
`ifdef BOOT_LOADER_VERIFY_EN
      S_VRD: begin
        if (ack) begin
          rd_d    = data_read;
          state_d = S_VREL;
        end else if (tmo_hit) begin
          err_d   = 2'b10;
          state_d = S_ERROR;
        end else tmo_d = tmo_q + TMO_ONE;
      end
      S_VREL: begin
        if (rd_q != wdata_q) begin
          err_d   = 2'b11;
          state_d = S_ERROR;
        end else begin
          cnt_d   = cnt_dec;
          addr_d  = addr_q + 24'd2;
          hi_d    = 1'b0;
          state_d = (cnt_dec != 16'd0) ? S_DATA : S_CSUM;
        end
      end
`endif
      S_CSUM: if (accept) begin
        if (rx_data == sum_q) begin
          addr_d  = 24'd0;
          wdata_d = 16'hA9A9;
          state_d = S_END_WR;
        end else begin
          err_d   = 2'b01;
          state_d = S_ERROR;
        end
      end
      S_END_WR: begin
        if (ack) state_d = S_END_REL;
        else if (tmo_hit) begin
          err_d   = 2'b10;
          state_d = S_ERROR;
        end else tmo_d = tmo_q + TMO_ONE;
      end
      S_END_REL: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: ;
    endcase
    // Outputs are decoded from the next state so they leave the flops aligned with it
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_HDR) ||
                 (state_d == S_DATA) || (state_d == S_CSUM);
    strb_d     = (state_d == S_WR) || (state_d == S_END_WR) || (state_d == S_VRD);
    rw_d       = !((state_d == S_WR) || (state_d == S_END_WR));
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      hdr_q      <= '0;
      hi_q       <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 2'b00;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      strb_q     <= 1'b0;
      rw_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef BOOT_LOADER_VERIFY_EN
      rd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      hdr_q      <= hdr_d;
      hi_q       <= hi_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
      strb_q     <= strb_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
`ifdef BOOT_LOADER_VERIFY_EN
      rd_q       <= rd_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign addr       = addr_q;
  assign data_write = wdata_q;
  assign uds        = strb_q;
  assign lds        = strb_q;
  assign rw         = rw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
endmodule

// File: tb/tb_boot_loader_master.sv
// Bench for boot_loader_master: bus responder with backing memory, image builder and expected-transfer model.
module tb_boot_loader_master;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [23:0] addr;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic        uds, lds, rw, ack, busy, done;
  logic [1:0]  error;

  typedef struct packed {logic rw; logic [23:0] a; logic [15:0] d;} xfer_t;

  xfer_t       log_q[$];
  xfer_t       exp_q[$];
  logic [15:0] words[$];
  logic [15:0] mem [logic [23:0]];
  int          n_pass = 0, n_total = 0;
  int          rises, hi_len, cur_len, wait_cnt, lane_err, stab_err, ack_delay;
  bit          no_ack, corrupt, prev_strb;
  logic [23:0] strb_addr;
  logic [15:0] strb_data;

  boot_loader_master #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .addr(addr), .data_write(data_write), .data_read(data_read), .uds(uds), .lds(lds),
    .rw(rw), .ack(ack), .busy(busy), .done(done), .error(error)
  );

  initial forever #5 clk = ~clk;

  // Bus responder: acks after ack_delay strobe cycles and logs each completed transfer
  initial begin
    ack = 1'b0; data_read = 16'h0; rises = 0; hi_len = 0; cur_len = 0; wait_cnt = 0;
    lane_err = 0; stab_err = 0; prev_strb = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      if (uds !== lds) lane_err++;
      if (uds === 1'b1) begin
        if (!prev_strb) begin
          rises++; cur_len = 0; wait_cnt = 0; strb_addr = addr; strb_data = data_write;
        end else if (addr !== strb_addr || data_write !== strb_data) stab_err++;
        cur_len++;
        if (!no_ack && wait_cnt >= ack_delay) begin
          ack = 1'b1;
          log_q.push_back({rw, addr, data_write});
          if (rw) data_read = (corrupt || !mem.exists(addr)) ? 16'h0000 : mem[addr];
          else mem[addr] = data_write;
        end
        wait_cnt++;
      end else if (prev_strb) hi_len = cur_len;
      prev_strb = (uds === 1'b1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_valid = 1'b0; no_ack = 1'b0; corrupt = 1'b0; ack_delay = 0;
    repeat (2) @(negedge clk);
    log_q.delete(); mem.delete();
    rises = 0; lane_err = 0; stab_err = 0; hi_len = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    rx_data = b; rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    ok = (t < 300);
    if (ok) @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_image(input logic [23:0] a, input bit bad, input int gap_max, output bit ok);
    logic [7:0]  s[$];
    logic [7:0]  sum = 8'h00;
    logic [15:0] n = 16'(words.size());
    bit          b_ok;
    s = '{a[23:16], a[15:8], a[7:0], n[15:8], n[7:0]};
    foreach (words[i]) begin
      s.push_back(words[i][15:8]); s.push_back(words[i][7:0]);
      sum = sum + words[i][15:8];
      sum = sum + words[i][7:0];
    end
    s.push_back(bad ? sum + 8'd1 : sum);
    ok = 1'b1;
    foreach (s[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(s[i], b_ok);
      if (!b_ok) ok = 1'b0;
    end
  endtask

  // Expected transfers: words at consecutive even addresses, then the end command on success
  task automatic build_expect(input logic [23:0] a, input bit bad);
    logic [23:0] p = {a[23:1], 1'b0};
    exp_q.delete();
    foreach (words[i]) begin
      exp_q.push_back({1'b0, p, words[i]});
`ifdef BOOT_LOADER_VERIFY_EN
      exp_q.push_back({1'b1, p, words[i]});
`endif
      p = p + 24'd2;
    end
    if (!bad) exp_q.push_back({1'b0, 24'h000000, 16'hA9A9});
  endtask

  task automatic wait_end(output bit ok);
    int t = 0;
    while (done !== 1'b1 && error === 2'b00 && t < 3000) begin @(negedge clk); t++; end
    ok = (t < 3000);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if ({addr, data_write} !== 40'h0) $display("FAIL reset_addr_data: got %h want 0", {addr, data_write}); else n_pass++;
    n_total++; if ({uds, lds, rw} !== 3'b001) $display("FAIL reset_strobes_rw: got %b want 001", {uds, lds, rw}); else n_pass++;
    n_total++; if ({rx_ready, busy, done, error} !== 5'b0) $display("FAIL reset_status: got %b want 00000", {rx_ready, busy, done, error}); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++; if (rx_ready !== 1'b1 || busy !== 1'b0) $display("FAIL idle_ready: got rdy=%b busy=%b want 1/0", rx_ready, busy); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok, e_ok;
    xfer_t got;
    do_reset();
    words = '{16'h1234, 16'hABCD};
    build_expect(24'h001000, 1'b0);
    send_image(24'h001000, 1'b0, 1, ok);
    wait_end(e_ok);
    n_total++; if (!(ok && e_ok)) $display("FAIL basic_progress: got acc=%0b end=%0b want 1/1", ok, e_ok); else n_pass++;
    n_total++; if (log_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : '0;
      n_total++; if (got !== exp_q[i]) $display("FAIL basic_xfer%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    n_total++; if ({done, error, busy} !== 4'b1000) $display("FAIL basic_status: got %b want 1000", {done, error, busy}); else n_pass++;
    n_total++; if (rises != log_q.size() || lane_err != 0 || stab_err != 0)
      $display("FAIL basic_bus: got rises=%0d lanes=%0d stab=%0d want %0d/0/0", rises, lane_err, stab_err, log_q.size()); else n_pass++;
  endtask

  task automatic test_empty();
    bit ok, e_ok;
    do_reset();
    words.delete();
    send_image(24'h00ABCD, 1'b0, 0, ok);
    wait_end(e_ok);
    n_total++; if (log_q.size() != 1) $display("FAIL empty_count: got %0d want 1", log_q.size()); else n_pass++;
    n_total++; if (log_q.size() > 0 && log_q[0] !== {1'b0, 24'h0, 16'hA9A9}) $display("FAIL empty_xfer: got %h want %h", log_q[0], {1'b0, 24'h0, 16'hA9A9}); else n_pass++;
    n_total++; if (done !== 1'b1 || error !== 2'b00 || !e_ok) $display("FAIL empty_done: got done=%b err=%b want 1/00", done, error); else n_pass++;
  endtask

  task automatic test_bad_checksum();
    bit ok, e_ok;
    xfer_t got;
    do_reset();
    words = '{16'h1234, 16'hABCD};
    build_expect(24'h001000, 1'b1);
    send_image(24'h001000, 1'b1, 0, ok);
    wait_end(e_ok);
    n_total++; if (log_q.size() != exp_q.size()) $display("FAIL badsum_count: got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : '0;
      n_total++; if (got !== exp_q[i]) $display("FAIL badsum_xfer%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    n_total++; if ({done, error, busy} !== 4'b0010) $display("FAIL badsum_status: got %b want 0010", {done, error, busy}); else n_pass++;
    repeat (5) @(negedge clk);
    n_total++; if (rx_ready !== 1'b0 || uds !== 1'b0) $display("FAIL badsum_terminal: got rdy=%b uds=%b want 0/0", rx_ready, uds); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok, b_ok;
    logic [7:0] s[$];
    do_reset();
    no_ack = 1'b1;
    s = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD};
    foreach (s[i]) send_byte(s[i], b_ok);
    wait_end(ok);
    n_total++; if (error !== 2'b10 || !ok) $display("FAIL timeout_error: got %b want 10", error); else n_pass++;
    n_total++; if (hi_len != 16) $display("FAIL timeout_len: got %0d want 16", hi_len); else n_pass++;
    n_total++; if ({uds, busy, done} !== 3'b000) $display("FAIL timeout_status: got %b want 000", {uds, busy, done}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit b_ok;
    int t = 0;
    logic [7:0] s[$];
    do_reset();
    no_ack = 1'b1;
    s = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h55, 8'hAA};
    foreach (s[i]) send_byte(s[i], b_ok);
    while (uds !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    n_total++; if (uds !== 1'b1) $display("FAIL midreset_strobe: got uds=%b want 1", uds); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if ({uds, lds, busy, done} !== 4'b0000) $display("FAIL midreset_drop: got %b want 0000", {uds, lds, busy, done}); else n_pass++;
    reset = 1'b0; no_ack = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok, e_ok;
    xfer_t got;
    do_reset();
    words = '{16'(($urandom)), 16'(($urandom))};
    build_expect(24'hFFFFFF, 1'b0);
    ack_delay = 2;
    send_image(24'hFFFFFF, 1'b0, 0, ok);
    wait_end(e_ok);
    n_total++; if (log_q.size() != exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", log_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < log_q.size()) ? log_q[i] : '0;
      n_total++; if (got !== exp_q[i]) $display("FAIL wrap_xfer%0d: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    n_total++; if (rises != log_q.size() || done !== 1'b1) $display("FAIL wrap_gaps: got rises=%0d done=%b want %0d/1", rises, done, log_q.size()); else n_pass++;
  endtask

`ifdef BOOT_LOADER_VERIFY_EN
  task automatic test_verify_mismatch();
    bit ok, e_ok;
    do_reset();
    corrupt = 1'b1;
    words = '{16'h1234, 16'hABCD};
    send_image(24'h001000, 1'b0, 0, ok);
    wait_end(e_ok);
    n_total++; if (error !== 2'b11) $display("FAIL verify_error: got %b want 11", error); else n_pass++;
    n_total++; if (log_q.size() != 2) $display("FAIL verify_count: got %0d want 2", log_q.size()); else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit ok, e_ok, bad;
    logic [23:0] a;
    xfer_t got;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      words.delete();
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) words.push_back(16'($urandom));
      a = 24'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      ack_delay = $urandom_range(0, 6);
      build_expect(a, bad);
      send_image(a, bad, 2, ok);
      wait_end(e_ok);
      n_total++; if (log_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", it, log_q.size(), exp_q.size()); else n_pass++;
      foreach (exp_q[i]) begin
        got = (i < log_q.size()) ? log_q[i] : '0;
        n_total++; if (got !== exp_q[i]) $display("FAIL rand%0d_xfer%0d: got %h want %h", it, i, got, exp_q[i]); else n_pass++;
      end
      n_total++; if ({done, error} !== (bad ? 3'b001 : 3'b100)) $display("FAIL rand%0d_status: got %b want %b", it, {done, error}, bad ? 3'b001 : 3'b100); else n_pass++;
      n_total++; if (lane_err != 0 || stab_err != 0 || rises != log_q.size())
        $display("FAIL rand%0d_bus: got lanes=%0d stab=%0d rises=%0d want 0/0/%0d", it, lane_err, stab_err, rises, log_q.size()); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    no_ack = 1'b0; corrupt = 1'b0; ack_delay = 0;
    test_reset();
    test_basic();
    test_empty();
    test_bad_checksum();
    test_timeout();
    test_reset_mid();
    test_wrap();
`ifdef BOOT_LOADER_VERIFY_EN
    test_verify_mismatch();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
